// File: rtl/vga_scan_engine.sv
// Parametrised VGA scan-out engine: four-segment H/V timing, replicated framebuffer
// addressing with a page-flipped base, and sync/DE delay-matched to the framebuffer read latency.
module vga_scan_engine #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_PW         = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_PW         = 2,
  parameter int V_BP         = 29,
  parameter bit HSYNC_POL    = 1'b0,
  parameter bit VSYNC_POL    = 1'b0,
  parameter int SCALE        = 4,
  parameter int PIX_WIDTH    = 12,
  parameter int VGABIT_WIDTH = 4,
  parameter int ADDR_WIDTH   = 16,
  parameter int FB_LATENCY   = 1
) (
  input  logic                    pix_clk,
  input  logic                    RST_X,
  input  logic                    en,
  input  logic [ADDR_WIDTH-1:0]   cfg_base,
  input  logic                    cfg_base_we,
  input  logic [PIX_WIDTH-1:0]    border,
  output logic [ADDR_WIDTH-1:0]   fb_addr,
  input  logic [PIX_WIDTH-1:0]    fb_rdata,
  output logic                    VGA_H_SYNC,
  output logic                    VGA_V_SYNC,
  output logic [VGABIT_WIDTH-1:0] VGA_RED,
  output logic [VGABIT_WIDTH-1:0] VGA_GREEN,
  output logic [VGABIT_WIDTH-1:0] VGA_BLUE,
  output logic                    VGA_DE,
  output logic                    frame_start,
  output logic                    flip_done
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_PW + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_PW + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int XN      = H_ACTIVE / SCALE;
  localparam int YN      = V_ACTIVE / SCALE;
  localparam int XW      = $clog2(XN + 1);
  localparam int YW      = $clog2(YN + 1);
  localparam int SW      = $clog2(SCALE + 1);
  localparam int CH_W    = PIX_WIDTH / 3;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_ALAST  = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_PW);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_PW);
  localparam logic [SW-1:0] S_LAST   = SW'(SCALE - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_W = ADDR_WIDTH'(XN);

  // Top VGABIT_WIDTH bits of each colour channel, red in the MSBs.
  function automatic logic [3*VGABIT_WIDTH-1:0] to_rgb(input logic [PIX_WIDTH-1:0] p);
    to_rgb = {p[3*CH_W-1 -: VGABIT_WIDTH], p[2*CH_W-1 -: VGABIT_WIDTH], p[CH_W-1 -: VGABIT_WIDTH]};
  endfunction

  logic [HW-1:0]         h_cnt;
  logic [VW-1:0]         v_cnt;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic [SW-1:0]         xwait;
  logic [SW-1:0]         ywait;
  logic [ADDR_WIDTH-1:0] active_base;
  logic [ADDR_WIDTH-1:0] pend_base;
  logic                  pending;

  // Stage 0: raster position decode
  logic act_p0, hs_p0, vs_p0, fs_p0, flip_p0, line_end_p0, frame_end_p0;

  assign act_p0       = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_p0        = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs_p0        = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  assign fs_p0        = (h_cnt == '0) && (v_cnt == '0);
  assign flip_p0      = pending && (h_cnt == '0) && (v_cnt == V_ACT);
  assign line_end_p0  = act_p0 && (h_cnt == H_ALAST);
  assign frame_end_p0 = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign flip_done    = flip_p0;

  always_ff @(posedge pix_clk) begin
    if (!RST_X) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_ff @(posedge pix_clk) begin
    if (!RST_X) begin
      x     <= '0;
      xwait <= '0;
    end else if (line_end_p0) begin
      x     <= '0;
      xwait <= '0;
    end else if (act_p0) begin
      if (xwait == S_LAST) begin
        xwait <= '0;
        x     <= x + 1'b1;
      end else begin
        xwait <= xwait + 1'b1;
      end
    end
  end

  always_ff @(posedge pix_clk) begin
    if (!RST_X || frame_end_p0) begin
      y     <= '0;
      ywait <= '0;
    end else if (line_end_p0) begin
      if (ywait == S_LAST) begin
        ywait <= '0;
        y     <= y + 1'b1;
      end else begin
        ywait <= ywait + 1'b1;
      end
    end
  end

  // A write landing in the flip cycle becomes the next pending base.
  always_ff @(posedge pix_clk) begin
    if (!RST_X) begin
      active_base <= '0;
      pending     <= 1'b0;
    end else begin
      if (flip_p0) begin
        active_base <= pend_base;
        pending     <= 1'b0;
      end
      if (cfg_base_we) pending <= 1'b1;
    end
  end

  always_ff @(posedge pix_clk) begin
    if (cfg_base_we) pend_base <= cfg_base;
  end

  // Stage 1: registered address; flag delay line bit k is stage 1+k
  logic [FB_LATENCY:0] act_p1, hs_p1, vs_p1, fs_p1;

  always_ff @(posedge pix_clk) begin
    if (!RST_X) begin
      fb_addr <= '0;
      act_p1  <= '0;
      hs_p1   <= '0;
      vs_p1   <= '0;
      fs_p1   <= '0;
    end else begin
      fb_addr <= active_base + ADDR_WIDTH'(y) * LINE_W + ADDR_WIDTH'(x);
      act_p1  <= {act_p1[FB_LATENCY-1:0], act_p0};
      hs_p1   <= {hs_p1[FB_LATENCY-1:0], hs_p0};
      vs_p1   <= {vs_p1[FB_LATENCY-1:0], vs_p0};
      fs_p1   <= {fs_p1[FB_LATENCY-1:0], fs_p0};
    end
  end

  // Output stage: samples fb_rdata in the cycle it becomes valid
  logic [3*VGABIT_WIDTH-1:0] rgb_p2;

  always_ff @(posedge pix_clk) begin
    if (!RST_X) begin
      rgb_p2      <= '0;
      VGA_DE      <= 1'b0;
      frame_start <= 1'b0;
      VGA_H_SYNC  <= ~HSYNC_POL;
      VGA_V_SYNC  <= ~VSYNC_POL;
    end else begin
      VGA_DE      <= act_p1[FB_LATENCY];
      frame_start <= fs_p1[FB_LATENCY];
      VGA_H_SYNC  <= hs_p1[FB_LATENCY] ? HSYNC_POL : ~HSYNC_POL;
      VGA_V_SYNC  <= vs_p1[FB_LATENCY] ? VSYNC_POL : ~VSYNC_POL;
      if (!act_p1[FB_LATENCY]) rgb_p2 <= '0;
      else if (en)             rgb_p2 <= to_rgb(fb_rdata);
      else                     rgb_p2 <= to_rgb(border);
    end
  end

  assign VGA_RED   = rgb_p2[3*VGABIT_WIDTH-1 -: VGABIT_WIDTH];
  assign VGA_GREEN = rgb_p2[2*VGABIT_WIDTH-1 -: VGABIT_WIDTH];
  assign VGA_BLUE  = rgb_p2[VGABIT_WIDTH-1:0];

endmodule

// File: doc/vga_scan_engine.md
Name: vga_scan_engine

Overview:
- Parametrised next-generation VGA scan-out engine; replaces the fixed-640x480 timing generator.
- Generates H/V timing from four-segment parameters (active, front porch, sync, back porch) with programmable sync polarity and integer pixel replication (SCALE).
- Issues framebuffer read addresses relative to a double-buffered base address (page flip at vblank) and delay-matches sync/DE to a configurable framebuffer read latency.
- Adds a border colour, a scan-out enable and a frame-start pulse for the CPU interrupt path; sits between the framebuf read port and the VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (cycles)
H_PW, 96, hsync pulse width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_PW, 2, vsync width
V_BP, 29, vertical back porch
HSYNC_POL, 0, active level of hsync (0 = active-low)
VSYNC_POL, 0, active level of vsync
SCALE, 4, replication factor, 1..16; H_ACTIVE and V_ACTIVE must be multiples of it
PIX_WIDTH, 12, framebuffer pixel width, multiple of 3
VGABIT_WIDTH, 4, per-channel DAC width, <= PIX_WIDTH/3
ADDR_WIDTH, 16, framebuffer address width
FB_LATENCY, 1, framebuffer read latency in cycles, 1..3

Ports:
pix_clk  in  1  pixel clock
RST_X  in  1  synchronous active-low reset
en  in  1  scan-out enable; 0 forces border colour in active area
cfg_base  in  ADDR_WIDTH  new frame base address
cfg_base_we  in  1  write strobe for cfg_base
border  in  PIX_WIDTH  colour shown in active area when en=0
fb_addr  out  ADDR_WIDTH  framebuffer read address (registered)
fb_rdata  in  PIX_WIDTH  framebuffer data, valid FB_LATENCY cycles after fb_addr
VGA_H_SYNC  out  1  hsync
VGA_V_SYNC  out  1  vsync
VGA_RED  out  VGABIT_WIDTH  red
VGA_GREEN  out  VGABIT_WIDTH  green
VGA_BLUE  out  VGABIT_WIDTH  blue
VGA_DE  out  1  data enable (active area), aligned with RGB
frame_start  out  1  one-cycle pulse at first active pixel of a frame, aligned with RGB
flip_done  out  1  one-cycle pulse when a pending base is applied

Behaviour:
- Clock: pix_clk only. Reset: synchronous, active-low (RST_X=0 sampled on pix_clk edge).
- Reset values: h_cnt=v_cnt=0; x, y, xwait, ywait=0; active_base=0; pending=0; fb_addr=0; RGB=0; VGA_DE=0; frame_start=0; flip_done=0; VGA_H_SYNC=~HSYNC_POL; VGA_V_SYNC=~VSYNC_POL.
- Reset mid-frame: counters restart at (0,0) the next cycle; the delay pipe is flushed to the blank/inactive state.
- Counters: H_TOTAL=H_ACTIVE+H_FP+H_PW+H_BP. h_cnt wraps at H_TOTAL-1. v_cnt increments on h_cnt wrap and wraps at V_TOTAL-1.
- Stage-0 flags: active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE. hs = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_PW). vs = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_PW), full lines. Stage-0 frame start = (h_cnt==0 && v_cnt==0).
- Address generation:
  - fb_addr = active_base + y*(H_ACTIVE/SCALE) + x, computed mod 2^ADDR_WIDTH.
  - fb_addr is registered and presented in the cycle after the stage-0 position is reached.
  - x advances when xwait==SCALE-1 in active cycles; x and xwait reset to 0 at the end of each active line.
  - y advances at the end of the last active pixel of a line when ywait==SCALE-1; y and ywait return to 0 at v_cnt==V_TOTAL-1, h_cnt==H_TOTAL-1.
  - SCALE=1 degenerates to one address per pixel.
- Page flip:
  - cfg_base_we loads pend_base and sets pending; a later write before the flip overwrites pend_base.
  - At h_cnt==0, v_cnt==V_ACTIVE (first blank line), if pending: active_base<=pend_base, pending<=0, flip_done=1 for one cycle.
  - A write in that same cycle is taken as the new pending value and is not applied until the next frame.
- Pixel path:
  - Stage-0 active, hs, vs and frame start are delayed by D=FB_LATENCY+1 cycles relative to fb_addr.
  - At output: if delayed active && en (en sampled at the output stage), RGB = top VGABIT_WIDTH bits of each PIX_WIDTH/3 channel of fb_rdata (R in MSBs).
  - If delayed active && !en: same mapping applied to border.
  - Else RGB=0.
  - VGA_DE = delayed active.
  - Syncs are output at the polarity given by HSYNC_POL/VSYNC_POL.

Test Plan:
- Small config (H 8/2/2/2, V 4/1/1/1, SCALE=2, FB_LATENCY=1); release reset -> VGA_H_SYNC period 14 cycles, low for 2; VGA_V_SYNC low for 14 cycles every 98; VGA_DE high for 8 cycles on each of 4 lines.
- Same config, fb model returning data=address -> fb_addr sequence per frame: lines 0,1 give 0,0,1,1,2,2,3,3; lines 2,3 give 4,4,5,5,6,6,7,7; RGB appears 2 cycles after the matching fb_addr.
- cfg_base=0x100 written mid-frame -> current frame unchanged; flip_done pulses at v_cnt=4, h_cnt=0; next frame first address 0x100. A second write in the flip cycle takes effect one frame later.
- en=0, border=0xF0A -> active RGB = F,0,A; blanking RGB=0; VGA_DE unchanged.
- HSYNC_POL=1, VSYNC_POL=1 -> syncs idle low and pulse high; reset drives both to 0.
- RST_X=0 mid-line for 1 cycle -> all outputs return to reset values next cycle; frame_start pulses D cycles after the first fb_addr following release.
